multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles per memory access, legal range 0..7.
REQ-002 SHALL have parameter TRAP_ON_ILLEGAL, default 1: 1 means an unsupported instruction enters TRAP; 0 means it returns to FETCH.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port opcode, input, 6 bits: IR[31:26], sampled in DECODE.
REQ-006 SHALL have port funct, input, 6 bits: IR[5:0], sampled in DECODE.
REQ-007 SHALL have outputs IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCWrite, and PCWriteCond, each 1 bit, with standard multicycle datapath meaning.
REQ-008 SHALL have outputs ALUSrcB, ALUOp, and PCSource, each 2 bits, with standard multicycle datapath meaning.
REQ-009 SHALL have output state, 4 bits: current state encoding, for debug.
REQ-010 SHALL have output trap, 1 bit: high while in TRAP.

Function
REQ-011 SHALL be a Moore FSM: all outputs are decoded from registered state and wait counter only, and state advances on the rising edge of clk.
REQ-012 SHALL use this state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12; codes 13-15 go to FETCH on the next edge.
REQ-013 SHALL drive every output not listed for a state as 0.
REQ-014 SHALL drive FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the final wait cycle.
REQ-015 SHALL drive DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-016 SHALL drive MEMADR and ADDIEX outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-017 SHALL drive MEMRD outputs: MemRead=1, IorD=1. SHALL drive MEMWR outputs: MemWrite=1, IorD=1.
REQ-018 SHALL drive MEMWB outputs: RegWrite=1, MemToReg=1, RegDst=0.
REQ-019 SHALL drive EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10. SHALL drive ALUWB outputs: RegWrite=1, RegDst=1.
REQ-020 SHALL drive BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-021 SHALL drive JUMP outputs: PCWrite=1, PCSource=10. SHALL drive ADDIWB outputs: RegWrite=1, RegDst=0.
REQ-022 SHALL drive TRAP outputs: trap=1, all control outputs 0.
REQ-023 SHALL hold FETCH, MEMRD, and MEMWR for MEM_WAIT+1 cycles using a 3-bit wait counter that is cleared on state entry and increments each held cycle; the state exits when the counter equals MEM_WAIT.
REQ-024 SHALL keep MemRead/MemWrite/IorD constant for the entire hold of a memory state.
REQ-025 SHALL make DECODE transitions: opcode 0x23 or 0x2B to MEMADR; 0x00 with funct in {0x20,0x22,0x24,0x25,0x2A} to EXEC; 0x04 to BRANCH; 0x02 to JUMP; 0x08 to ADDIEX.
REQ-026 SHALL treat any other opcode, or opcode 0x00 with any other funct, as illegal: TRAP if TRAP_ON_ILLEGAL=1, else FETCH.
REQ-027 SHALL transition MEMADR to MEMRD when the DECODE-latched opcode is 0x23, else to MEMWR; the opcode SHALL be latched in DECODE so that later opcode changes are ignored.
REQ-028 SHALL make these fixed transitions: MEMRD to MEMWB; EXEC to ALUWB; ADDIEX to ADDIWB; MEMWB, MEMWR (after wait), ALUWB, ADDIWB, BRANCH, and JUMP to FETCH.
REQ-029 SHALL keep TRAP until reset.
REQ-030 SHALL give these instruction latencies with MEM_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-031 SHALL, when reset=1 at a rising edge, set state to FETCH, clear the wait counter, and clear the latched opcode, regardless of current state; this includes mid-wait and TRAP.
REQ-032 SHALL give reset priority over every transition.
REQ-033 SHALL, in the first cycle after reset, drive FETCH outputs with the wait counter at 0: MemRead=1, ALUSrcB=01, and IRWrite=PCWrite=1 only if MEM_WAIT=0.

Verification
REQ-034 SHALL be verified for lw: MEM_WAIT=0, opcode=0x23 -> states 0,1,2,3,4,0; MemToReg=1 and RegWrite=1 in state 4 only.
REQ-035 SHALL be verified for wait states: MEM_WAIT=2, sw opcode=0x2B -> FETCH 3 cycles with IRWrite only in the 3rd; MEMWR 3 cycles with MemWrite=1 throughout; total 8 cycles.
REQ-036 SHALL be verified for R-type: opcode=0x00, funct=0x2A -> 0,1,6,7,0; ALUOp=10 in EXEC; RegDst=1 in ALUWB. funct=0x21 with TRAP_ON_ILLEGAL=1 -> state 12, trap=1, held 10 cycles.
REQ-037 SHALL be verified for beq/j: opcode=0x04 -> BRANCH with PCWriteCond=1, PCSource=01; opcode=0x02 -> JUMP with PCWrite=1, PCSource=10; each 3 cycles.
REQ-038 SHALL be verified for reset mid-operation: reset in the 2nd MEMRD wait cycle (MEM_WAIT=3) -> FETCH next cycle with wait counter 0; reset in TRAP -> FETCH.
REQ-039 SHALL be verified for opcode change after DECODE: opcode changes 0x23 to 0x2B during MEMADR -> still MEMRD.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control unit for a multicycle MIPS-style datapath
// Ports: clk, reset (sync, active-high); opcode/funct (IR fields, sampled in DECODE);
//        datapath controls IorD..PCSource; state (debug encoding); trap (high in TRAP).
// Params: MEM_WAIT (0..7 extra cycles per memory access), TRAP_ON_ILLEGAL (1: TRAP, 0: FETCH).
module multicycle_control_fsm #(
  parameter int MEM_WAIT = 0,
  parameter bit TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       trap
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    ADDIEX = 4'd10, ADDIWB = 4'd11, TRAP = 4'd12
  } state_t;
  localparam logic [2:0] WAIT = 3'(MEM_WAIT);
  localparam state_t ILL = TRAP_ON_ILLEGAL ? TRAP : FETCH;
  state_t cur, nxt;
  logic [2:0] cnt;
  logic [5:0] op_q;
  logic done, rtype_ok, mem_state;
  assign done = cnt == WAIT;
  assign rtype_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign mem_state = cur inside {FETCH, MEMRD, MEMWR};
  assign state = cur;
  // Counter restarts at 0 whenever a state is entered, so it only counts inside a memory hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      cnt <= '0;
      op_q <= '0;
    end else begin
      cur <= nxt;
      cnt <= (mem_state && !done) ? cnt + 3'd1 : 3'd0;
      if (cur == DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = done ? DECODE : FETCH;
      DECODE: nxt = (opcode == 6'h23 || opcode == 6'h2B) ? MEMADR :
                    (opcode == 6'h00) ? (rtype_ok ? EXEC : ILL) :
                    (opcode == 6'h04) ? BRANCH :
                    (opcode == 6'h02) ? JUMP :
                    (opcode == 6'h08) ? ADDIEX : ILL;
      MEMADR: nxt = (op_q == 6'h23) ? MEMRD : MEMWR;
      MEMRD:  nxt = done ? MEMWB : MEMRD;
      MEMWR:  nxt = done ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end
  always_comb begin
    {IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCWrite, PCWriteCond} = '0;
    {ALUSrcB, ALUOp, PCSource} = '0;
    trap = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = done;
        PCWrite = done;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: {MemRead, IorD} = 2'b11;
      MEMWR: {MemWrite, IorD} = 2'b11;
      MEMWB: {RegWrite, MemToReg} = 2'b11;
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
      end
      ALUWB: {RegWrite, RegDst} = 2'b11;
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      TRAP: trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: checks three parameterisations against an instruction-level model
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [2:0][20:0] obs;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : dut
    logic iord, mr, mwr, m2r, irw, rd, rw, asa, pcw, pcwc, tr;
    logic [1:0] asb, aop, pcs;
    logic [3:0] st;
    multicycle_control_fsm #(.MEM_WAIT(g == 0 ? 0 : g == 1 ? 2 : 3), .TRAP_ON_ILLEGAL(g != 2)) u (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .IorD(iord), .MemRead(mr), .MemWrite(mwr), .MemToReg(m2r), .IRWrite(irw), .RegDst(rd),
      .RegWrite(rw), .ALUSrcA(asa), .PCWrite(pcw), .PCWriteCond(pcwc), .ALUSrcB(asb),
      .ALUOp(aop), .PCSource(pcs), .state(st), .trap(tr)
    );
    assign obs[g] = {st, tr, iord, mr, mwr, m2r, irw, rd, rw, asa, pcw, pcwc, asb, aop, pcs};
  end
  function automatic int mw_of(int g);
    return g == 0 ? 0 : g == 1 ? 2 : 3;
  endfunction
  function automatic bit til_of(int g);
    return g != 2;
  endfunction
  // {state, trap, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSource}
  function automatic logic [20:0] out(int s, bit last);
    logic tr = 0, iord = 0, mr = 0, mwr = 0, m2r = 0, irw = 0, rd = 0, rw = 0, asa = 0, pcw = 0, pcwc = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (s)
      0: begin mr = 1; asb = 2'b01; irw = last; pcw = last; end
      1: asb = 2'b11;
      2, 10: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9: begin pcw = 1; pcs = 2'b10; end
      11: rw = 1;
      12: tr = 1;
      default: ;
    endcase
    return {4'(s), tr, iord, mr, mwr, m2r, irw, rd, rw, asa, pcw, pcwc, asb, aop, pcs};
  endfunction
  // Expected outputs k cycles after reset while opcode/funct are held: instructions repeat back to back.
  function automatic logic [20:0] exp_at(int mw, bit til, logic [5:0] op, logic [5:0] fn, int k);
    int seq[$];
    int t;
    bit stuck = 0;
    for (int i = 0; i <= mw; i++) seq.push_back(0);
    seq.push_back(1);
    if (op == 6'h23) begin
      seq.push_back(2);
      for (int i = 0; i <= mw; i++) seq.push_back(3);
      seq.push_back(4);
    end else if (op == 6'h2B) begin
      seq.push_back(2);
      for (int i = 0; i <= mw; i++) seq.push_back(5);
    end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
      seq.push_back(6);
      seq.push_back(7);
    end else if (op == 6'h04) seq.push_back(8);
    else if (op == 6'h02) seq.push_back(9);
    else if (op == 6'h08) begin
      seq.push_back(10);
      seq.push_back(11);
    end else if (til) begin
      seq.push_back(12);
      stuck = 1;
    end
    t = stuck ? (k < seq.size() ? k : seq.size() - 1) : k % seq.size();
    return out(seq[t], seq[t] == 0 && t == mw);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int g, input int k, input logic [20:0] got, input logic [20:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle%0d: got %h expected %h", tag, g, k, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input int n);
    opcode = op;
    funct = fn;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < 3; g++) chk(tag, g, k, obs[g], exp_at(mw_of(g), til_of(g), op, fn, k));
      tick();
    end
  endtask
  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h02, 6'h08, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    tick();
    run("lw", 6'h23, 6'h00, 12);
    run("sw", 6'h2B, 6'h00, 12);
    run("slt", 6'h00, 6'h2A, 10);
    run("illegal_funct", 6'h00, 6'h21, 14);
    run("beq", 6'h04, 6'h00, 8);
    run("j", 6'h02, 6'h00, 8);
    run("addi", 6'h08, 6'h00, 10);
    run("illegal_op", 6'h11, 6'h00, 10);
    // reset during the 2nd MEMRD wait cycle of the MEM_WAIT=3 instance
    opcode = 6'h23;
    funct = 6'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("in_memrd", 2, 7, {17'd0, obs[2][20:17]}, 21'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("after_mid_reset", 2, k, obs[2], exp_at(3, 0, 6'h23, 6'h00, k));
      tick();
    end
    // reset out of TRAP
    opcode = 6'h00;
    funct = 6'h21;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("in_trap", 0, 5, {16'd0, obs[0][20:16]}, {16'd0, 4'd12, 1'b1});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("after_trap_reset", 0, 0, obs[0], exp_at(0, 1, 6'h00, 6'h21, 0));
    // opcode changes during MEMADR must not redirect a load
    opcode = 6'h23;
    funct = 6'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("memadr", 0, 2, obs[0], exp_at(0, 1, 6'h23, 6'h00, 2));
    opcode = 6'h2B;
    tick();
    chk("latched_lw", 0, 3, obs[0], exp_at(0, 1, 6'h23, 6'h00, 3));
    for (int r = 0; r < 30; r++) begin
      op = ops[$urandom_range(7)];
      fn = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(5)];
      if (op == 6'h3F) op = 6'($urandom);
      run("random", op, fn, 16);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
